aoi_sweep_ctrl: RTL and testbench

Self-checking sequencer for the AOI gate block: a,b,c,d in; e = a&b, f = c&d, g = ~(e|f) out.
On a start pulse it drives all 16 input combinations into the AOI, waits a programmable settle time, samples e/f/g and compares them with a golden model.
It reports an error count, the first failing vector and a pass flag.
It sits beside the AOI instance on the lab board top, replacing free-running delay-based stimulus with a clocked, repeatable sweep.

---
 rtl/aoi_pkg.sv | 17 +
 rtl/aoi_sweep_ctrl_if.sv | 13 +
 rtl/aoi_sweep_cnt.sv | 40 ++++
 rtl/aoi_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_aoi_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aoi_pkg.sv
// Shared types and golden model for the AOI sweep controller.
package aoi_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] VEC_LAST = 4'd15;

  // Expected {e, f, g} for vector v, where v[0] drives a and v[3] drives d.
  function automatic logic [2:0] aoi_ref(input logic [3:0] v);
    logic ab;
    logic cd;
    ab = v[0] & v[1];
    cd = v[2] & v[3];
    return {ab, cd, ~(ab | cd)};
  endfunction

endpackage

// File: rtl/aoi_sweep_ctrl_if.sv
// Link between the sweep controller and the AOI gate block under test.
interface aoi_sweep_ctrl_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  modport master (output a, b, c, d, input e, f, g);
  modport slave  (input a, b, c, d, output e, f, g);
endinterface

// File: rtl/aoi_sweep_cnt.sv
// Vector index counter plus the settle-time counter used while waiting on the AOI.
module aoi_sweep_cnt
  import aoi_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vec_clr,
  input  logic       vec_inc,
  input  logic       settle_clr,
  input  logic       settle_inc,
  output logic [3:0] vec,
  output logic       last,
  output logic       expire
);

  // With SETTLE==0 the WAIT state is skipped, so the terminal value is never used.
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  logic [3:0] settle_cnt;

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else begin
      if (vec_clr)      vec <= '0;
      else if (vec_inc) vec <= vec + 4'd1;

      if (settle_clr)      settle_cnt <= '0;
      else if (settle_inc) settle_cnt <= settle_cnt + 4'd1;
    end
  end

  assign last   = (vec == VEC_LAST);
  assign expire = (settle_cnt == SETTLE_LAST);

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// Clocked 16-vector sweep of the AOI block with golden-model checking and result capture.
module aoi_sweep_ctrl
  import aoi_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  aoi_sweep_ctrl_if.master        aoi,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [3:0]              vec,
  output logic [4:0]              err_cnt,
  output logic [3:0]              fail_vec,
  output logic                    fail_valid
);

  state_t     state, state_nx;
  logic       vec_clr, vec_inc, settle_clr, settle_inc;
  logic       last, expire;
  logic       abort_now, check_fail;
  logic [3:0] drive_q;

  aoi_sweep_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .vec_clr    (vec_clr),
    .vec_inc    (vec_inc),
    .settle_clr (settle_clr),
    .settle_inc (settle_inc),
    .vec        (vec),
    .last       (last),
    .expire     (expire)
  );

  assign busy      = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == 5'd0);
  assign abort_now = busy && abort;
  // A vector caught by an abort is not scored; partial results stay as they were.
  assign check_fail = (state == CHECK) && !abort
                      && ({aoi.e, aoi.f, aoi.g} != aoi_ref(vec));

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nx   = state;
    vec_clr    = 1'b0;
    vec_inc    = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nx = DRIVE;
          vec_clr  = 1'b1;
        end
      end
      DRIVE: begin
        settle_clr = 1'b1;
        state_nx   = (SETTLE == 0) ? CHECK : WAIT;
      end
      WAIT: begin
        if (expire) state_nx = CHECK;
        else        settle_inc = 1'b1;
      end
      CHECK: begin
        if (last) begin
          state_nx = DONE;
        end else begin
          state_nx = DRIVE;
          vec_inc  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort_now) begin
      state_nx   = IDLE;
      vec_inc    = 1'b0;
      settle_clr = 1'b0;
      settle_inc = 1'b0;
    end
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drive_q    <= '0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      state <= state_nx;

      if (abort_now)           drive_q <= '0;
      else if (state == DRIVE) drive_q <= vec;

      if (vec_clr) begin
        err_cnt    <= '0;
        fail_vec   <= '0;
        fail_valid <= 1'b0;
      end else if (check_fail) begin
        err_cnt <= err_cnt + 5'd1;
        if (!fail_valid) begin
          fail_vec   <= vec;
          fail_valid <= 1'b1;
        end
      end
    end
  end

  assign {aoi.d, aoi.c, aoi.b, aoi.a} = drive_q;

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Scoreboard bench: a SETTLE=2 controller with injectable AOI faults and a SETTLE=0 controller.
module tb_aoi_sweep_ctrl;
  import aoi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0, abort2 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
  logic fault_g0 = 1'b0, fault_e1 = 1'b0;

  logic       busy2, done2, pass2, fvalid2;
  logic [3:0] vec2, fvec2;
  logic [4:0] err2;
  logic       busy0, done0, pass0, fvalid0;
  logic [3:0] vec0, fvec0;
  logic [4:0] err0;

  aoi_sweep_ctrl_if bus2 ();
  aoi_sweep_ctrl_if bus0 ();

  // AOI models; the SETTLE=2 one can have e stuck at 1 or g stuck at 0.
  assign bus2.e = fault_e1 ? 1'b1 : (bus2.a & bus2.b);
  assign bus2.f = bus2.c & bus2.d;
  assign bus2.g = fault_g0 ? 1'b0 : ~((bus2.a & bus2.b) | (bus2.c & bus2.d));
  assign bus0.e = bus0.a & bus0.b;
  assign bus0.f = bus0.c & bus0.d;
  assign bus0.g = ~((bus0.a & bus0.b) | (bus0.c & bus0.d));

  aoi_sweep_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .aoi(bus2),
    .busy(busy2), .done(done2), .pass(pass2), .vec(vec2),
    .err_cnt(err2), .fail_vec(fvec2), .fail_valid(fvalid2)
  );

  aoi_sweep_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .aoi(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .vec(vec0),
    .err_cnt(err0), .fail_vec(fvec0), .fail_valid(fvalid0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] err;
    logic [3:0] fv;
    logic       fvv;
    logic       pas;
    int         len;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int e, input int fv, input int fvv, input int pas, input int len);
    exp_t x;
    x.err = 5'(e);
    x.fv  = 4'(fv);
    x.fvv = fvv[0];
    x.pas = pas[0];
    x.len = len;
    return x;
  endfunction

  // Monitors: on each rising done, pop the expected sweep result and compare.
  int   bstart2 = 0, bstart0 = 0;
  logic busy2_d = 1'b0, done2_d = 1'b0, busy0_d = 1'b0, done0_d = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    if (busy2 && !busy2_d) bstart2 = cyc;
    if (done2 && !done2_d) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s2_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        x = q2.pop_front();
        check("s2_len",      cyc - bstart2, x.len);
        check("s2_err_cnt",  err2, x.err);
        check("s2_fail_vec", fvec2, x.fv);
        check("s2_fvalid",   fvalid2, x.fvv);
        check("s2_pass",     pass2, x.pas);
        check("s2_abcd",     {bus2.d, bus2.c, bus2.b, bus2.a}, 4'hF);
      end
    end
    busy2_d = busy2;
    done2_d = done2;
  end

  always @(negedge clk) begin
    exp_t x;
    if (busy0 && !busy0_d) bstart0 = cyc;
    if (done0 && !done0_d) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s0_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        x = q0.pop_front();
        check("s0_len",     cyc - bstart0, x.len);
        check("s0_err_cnt", err0, x.err);
        check("s0_fvalid",  fvalid0, x.fvv);
        check("s0_pass",    pass0, x.pas);
      end
    end
    busy0_d = busy0;
    done0_d = done0;
  end

  task automatic check_reset2(input string tag);
    check({tag, "_abcd"},   {bus2.d, bus2.c, bus2.b, bus2.a}, 0);
    check({tag, "_vec"},    vec2, 0);
    check({tag, "_busy"},   busy2, 0);
    check({tag, "_done"},   done2, 0);
    check({tag, "_pass"},   pass2, 0);
    check({tag, "_err"},    err2, 0);
    check({tag, "_fvec"},   fvec2, 0);
    check({tag, "_fvalid"}, fvalid2, 0);
  endtask

  // Returns at the negedge after the start edge, where busy has just risen.
  task automatic pulse_start2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  endtask

  task automatic wait_done2();
    int n = 0;
    while (!done2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s2_done_reached", done2, 1);
  endtask

  task automatic wait_vec2(input logic [3:0] v);
    int n = 0;
    while (vec2 !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s2_vec_reached", vec2, v);
  endtask

  task automatic run2(input exp_t x);
    q2.push_back(x);
    pulse_start2();
    check("s2_busy_rise",   busy2, 1);
    check("s2_start_err",   err2, 0);
    check("s2_start_fval",  fvalid2, 0);
    wait_done2();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset2("rst0");
    rst = 1'b0;

    run2(mk(0, 0, 0, 1, 64));
    fault_g0 = 1'b1;
    run2(mk(9, 0, 1, 0, 64));
    fault_g0 = 1'b0;
    fault_e1 = 1'b1;
    run2(mk(12, 0, 1, 0, 64));
    fault_e1 = 1'b0;
    run2(mk(0, 0, 0, 1, 64));

    // start while busy is ignored: sweep length and result unchanged.
    q2.push_back(mk(0, 0, 0, 1, 64));
    pulse_start2();
    wait_vec2(4'd3);
    pulse_start2();
    wait_done2();

    // abort while vector 7 is being driven; vectors 0..6 were checked with g stuck at 0.
    fault_g0 = 1'b1;
    pulse_start2();
    wait_vec2(4'd7);
    abort2 = 1'b1;
    @(negedge clk) abort2 = 1'b0;
    check("abort_busy",   busy2, 0);
    check("abort_done",   done2, 0);
    check("abort_abcd",   {bus2.d, bus2.c, bus2.b, bus2.a}, 0);
    check("abort_err",    err2, 6);
    check("abort_fvec",   fvec2, 0);
    check("abort_fvalid", fvalid2, 1);
    fault_g0 = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_done", done2, 0);

    // abort and start together in IDLE: nothing starts, results untouched.
    start2 = 1'b1;
    abort2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    abort2 = 1'b0;
    @(negedge clk);
    check("ab_st_busy",   busy2, 0);
    check("ab_st_err",    err2, 6);
    check("ab_st_fvalid", fvalid2, 1);

    // synchronous reset mid-sweep.
    pulse_start2();
    wait_vec2(4'd10);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset2("rst10");
    repeat (70) @(negedge clk);
    check("rst10_no_done", done2, 0);

    // SETTLE=0: a new vector on a..d every 2 cycles, done after 32.
    q0.push_back(mk(0, 0, 0, 1, 32));
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int m = 2; m <= 33; m++) begin
      @(negedge clk);
      check("s0_vec_step", {bus0.d, bus0.c, bus0.b, bus0.a}, (m - 2) / 2);
    end
    repeat (3) @(negedge clk);
    check("s0_done_level", done0, 1);

    check("q2_drained", q2.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
